alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU between two requesters, e.g. the execute path and a future multicycle/debug path.
- Arbitrates between the requesters and latches the winning operands.
- Drives the ALU for one cycle and registers the result and error.
- Maintains the architectural Z/V/N flag register with per-opcode update rules, and returns the response with a valid/ready handshake.

Parameters:
- DW, 16, datapath width of operands and result.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req_op0, req_op1  in  3 each  opcode: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADSUB
- req_a0, req_a1  in  DW each  operand 1
- req_b0, req_b1  in  DW each  operand 2
- rsp_valid  out  2  response valid, one-hot to the granted requester
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  DW  registered ALU result
- rsp_err  out  1  registered ALU error (overflow)
- flags  out  3  [2]=Z, [1]=V, [0]=N
- alu_in1, alu_in2  out  DW  to shared ALU
- alu_op  out  3  to shared ALU
- alu_out  in  DW  from shared ALU (combinational)
- alu_err  in  1  from shared ALU

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM returns to IDLE; last-grant pointer = 1, so requester 0 wins first.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, flags = 000.
  - Operand registers and alu_* outputs = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, pick a winner g.
  - RR_EN=1: the requester other than the last grant wins on a tie; a lone requester always wins.
  - RR_EN=0: requester 0 wins on a tie.
  - req_ready[g] = 1 combinationally in this cycle (accept = valid & ready).
  - Latch op/a/b of g and the grant id; go to EXEC.
  - With no valid, stay in IDLE.
- EXEC:
  - alu_in1/alu_in2/alu_op are driven from the latched registers (registered outputs, stable for the whole cycle).
  - At the clock edge, capture rsp_data <= alu_out and rsp_err <= alu_err.
  - At the same edge, update flags per the rules below; go to RESP.
- RESP:
  - rsp_valid[g] = 1; rsp_data and rsp_err held stable.
  - When rsp_ready[g] = 1, rsp_valid drops on the next edge, last-grant <= g, and the FSM goes to IDLE.
  - rsp_ready of the non-granted requester is ignored.
  - No new request is accepted in EXEC or RESP (req_ready = 0).
- Latency: accept edge at cycle 0, rsp_valid high from cycle 2. Minimum 3 cycles per operation.
- Flag update in EXEC:
  - ADD, SUB: Z = (alu_out == 0), V = alu_err, N = alu_out[DW-1].
  - XOR, SLL, SRA, ROR: only Z is updated; V and N are retained.
  - RED, PADSUB: flags are unchanged.
- Flags change only on the EXEC edge and are visible from cycle 2, coincident with rsp_valid.
- Simultaneous events:
  - A req_valid held by the granted requester during RESP is a new request, arbitrated in IDLE.
  - The loser of a tie keeps its request pending; it must hold req_valid and operands stable until accepted.
- Reset mid-operation: any in-flight op is dropped with no response; the flags change neither for it nor afterwards until a new EXEC.

Decomposition:
- Shared package holds:
  - the opcode enum (ADD..PADSUB, 3 bits);
  - flag bit index constants ZF=2, VF=1, NF=0;
  - the FSM state typedef (IDLE, EXEC, RESP);
  - a function returning the {Z,V,N} update mask per opcode.
- The ALU itself stays external and is wired to the alu_* ports.
- One natural sub-module: rr_arb2, a 2-way round-robin/fixed arbiter with a last-grant register input and one-hot grant output.

Test Plan (bench connects the team's ALU to alu_*):
- Req0 ADD a=0x7FFF b=0x0001 -> req_ready[0] at cycle 0; rsp_valid[0] at cycle 2; rsp_data=0x8000, rsp_err=1, flags=011.
- Both requesters valid right after reset, req0 SUB 5-5, req1 XOR 0x00F0^0x000F:
  - req0 served first: data 0x0000, flags=100.
  - req1 served next: data 0x00FF, Z=0, V/N retained, flags=000.
  - Next tie: req0 wins again (RR_EN=1).
- Same tie with RR_EN=0, back-to-back tied requests -> req0 always wins; req1 starves while req0 stays valid.
- Flags=011 preset, then RED and PADSUB ops -> flags stay 011; rsp_data equals the ALU output.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready stays 0 with req1 valid; ready=1 -> IDLE next edge, req1 accepted.
- Assert rst_n=0 during EXEC of an ADD -> outputs zero asynchronously, no rsp_valid after release, flags=000.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: opcodes, flag indices, FSM states and
// the per-opcode flag update mask.
package alu_arbiter_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADSUB = 3'b111
    } alu_op_e;

    localparam int unsigned ZF = 2;
    localparam int unsigned VF = 1;
    localparam int unsigned NF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Bits set in the mask are overwritten by the new {Z,V,N}; others are retained.
    function automatic logic [2:0] flag_mask(input alu_op_e op);
        logic [2:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB:                 m = '1;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[ZF] = 1'b1;
            default:                        m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin against a last-grant bit, or fixed priority
// to requester 0. Grant is one-hot, or zero when nothing is requested.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that was not served last wins.
            2'b11:   grant = (RR_EN && !last) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, registers
// its result/error and maintains the Z/V/N flag register.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter bit          RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [2:0]    req_op0,
    input  logic [2:0]    req_op1,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_b1,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [2:0]    flags,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_err
);

    state_e        state, state_nxt;
    logic          last_grant;
    logic          gid;
    logic [1:0]    grant;
    logic [2:0]    op_q;
    logic [DW-1:0] a_q, b_q;
    logic [2:0]    new_flags;
    logic [2:0]    mask;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .valid (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign alu_in1 = a_q;
    assign alu_in2 = b_q;
    assign alu_op  = op_q;

    assign new_flags = {(alu_out == '0), alu_err, alu_out[DW-1]};
    assign mask      = flag_mask(alu_op_e'(op_q));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (|req_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[gid] = 1'b1;
                if (rsp_ready[gid]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            gid        <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            flags      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gid  <= grant[1];
                        op_q <= grant[1] ? req_op1 : req_op0;
                        a_q  <= grant[1] ? req_a1  : req_a0;
                        b_q  <= grant[1] ? req_b1  : req_b0;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    rsp_err  <= alu_err;
                    flags    <= (flags & ~mask) | (new_flags & mask);
                end
                RESP: begin
                    if (rsp_ready[gid]) last_grant <= gid;
                end
                default: ;
            endcase
        end
    end

endmodule
